// File: rtl/fp16_pkg.sv
// Shared types and constants for the half-precision sequential ALU.
package fp16_pkg;
  typedef enum logic [1:0] {FP_ADD = 2'd0, FP_SUB = 2'd1, FP_MUL = 2'd2, FP_CMP = 2'd3} fp_op_e;

  localparam logic [1:0] OFUF_OK = 2'b00;
  localparam logic [1:0] OFUF_UF = 2'b01;
  localparam logic [1:0] OFUF_OF = 2'b10;

  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int BIAS  = 15;

  localparam logic [15:0] FP16_ONE    = 16'h3C00;
  localparam logic [14:0] FP16_MAXMAG = 15'h7BFF;

  typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, MUL, NORM, PACK} state_e;

  function automatic logic [EXP_W-1:0] fp_exp(input logic [15:0] v);
    return v[MAN_W+EXP_W-1:MAN_W];
  endfunction
endpackage

// File: rtl/fp16_normalize.sv
// Combinational normalizer: 15-bit magnitude (bit 13 = hidden-one position,
// bit 14 = carry) to a 14-bit significand with the hidden one at bit 13.
module fp16_normalize
  import fp16_pkg::*;
(
  input  logic        [14:0] mag,
  input  logic signed [6:0]  exp_in,
  output logic        [13:0] sig,
  output logic signed [6:0]  exp_out
);
  logic [3:0] lz;

  always_comb begin
    lz = 4'd0;
    for (int i = 0; i < 14; i++) begin
      if (mag[i]) lz = 4'(13 - i);
    end
    sig     = mag[13:0];
    exp_out = exp_in;
    // A carry shifts right by one; the dropped bit folds into the sticky position.
    if (mag[14]) begin
      sig     = {mag[14:2], mag[1] | mag[0]};
      exp_out = exp_in + 7'sd1;
    end else if (mag[13:0] != 14'd0) begin
      sig     = mag[13:0] << lz;
      exp_out = exp_in - $signed({3'b000, lz});
    end
  end
endmodule

// File: rtl/fp16_seq_alu.sv
// Multi-cycle binary16 add/sub/mul/compare responder with start/done handshake.
// Define FP16_ALU_RNE_EN for round-to-nearest-even packing; default truncates.
module fp16_seq_alu
  import fp16_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [1:0]  opcode,
  output logic [15:0] result,
  output logic        done,
  output logic [1:0]  OFUF,
  output logic [2:0]  compResult
);
  state_e state, state_nx;
  logic [3:0] cnt;

  logic [15:0] xl, yl;
  fp_op_e op;
  logic sa, sb, sgn;
  logic signed [6:0] ea, eb, exp_w, n_exp, norm_exp;
  logic [13:0] ma, mb, n_sig, norm_sig;
  logic [14:0] mag_w, norm_mag, addsum;
  logic [21:0] acc, mcand;
  logic [10:0] mplier;

  function automatic logic [13:0] unpack_sig(input logic [15:0] v);
    if (fp_exp(v) == 5'd0) return 14'd0;
    if (fp_exp(v) == 5'd31) return 14'h2000;
    return {1'b1, v[9:0], 3'b000};
  endfunction

  function automatic logic [17:0] pack_fp(input logic s, input logic signed [6:0] e,
                                          input logic [13:0] sig);
    logic [9:0] m;
    logic signed [6:0] ee;
    m  = sig[12:3];
    ee = e;
`ifdef FP16_ALU_RNE_EN
    begin
      logic [10:0] mr;
      mr = {1'b0, sig[12:3]} + {10'd0, sig[2] & (sig[1] | sig[0] | sig[3])};
      m  = mr[9:0];
      if (mr[10]) ee = e + 7'sd1;
    end
`endif
    if (sig == 14'd0) return {OFUF_OK, s, 15'd0};
    if (ee >= 7'sd31) return {OFUF_OF, s, FP16_MAXMAG};
    if (ee <= 7'sd0) return {OFUF_UF, s, 15'd0};
    return {OFUF_OK, s, ee[4:0], m};
  endfunction

  function automatic logic [2:0] cmp_fp(input logic [15:0] a, input logic [15:0] b);
    logic [14:0] am, bm;
    am = (fp_exp(a) == 5'd0) ? 15'd0 : a[14:0];
    bm = (fp_exp(b) == 5'd0) ? 15'd0 : b[14:0];
    if (am == 15'd0 && bm == 15'd0) return 3'b010;
    if (a[15] != b[15]) return a[15] ? 3'b001 : 3'b100;
    if (am == bm) return 3'b010;
    return ((am > bm) ^ a[15]) ? 3'b100 : 3'b001;
  endfunction

  logic signed [6:0] ux_e, uy_e, big_e, small_e, diff;
  logic [13:0] ux_sig, uy_sig;
  logic x_big;
  logic [3:0] sh;
  logic [17:0] pk;

  assign ux_e    = $signed({2'b00, fp_exp(xl)});
  assign uy_e    = $signed({2'b00, fp_exp(yl)});
  assign ux_sig  = unpack_sig(xl);
  assign uy_sig  = unpack_sig(yl);
  assign x_big   = {ea, ma} >= {eb, mb};
  assign big_e   = x_big ? ea : eb;
  assign small_e = x_big ? eb : ea;
  assign diff    = big_e - small_e;
  assign sh      = (diff > 7'sd13) ? 4'd13 : diff[3:0];
  assign addsum  = (sa == sb) ? ({1'b0, ma} + {1'b0, mb}) : ({1'b0, ma} - {1'b0, mb});
  assign norm_mag = (op == FP_MUL) ? {acc[21:8], |acc[7:0]} : mag_w;
  assign pk      = pack_fp(sgn, n_exp, n_sig);

  fp16_normalize u_norm (
    .mag    (norm_mag),
    .exp_in (exp_w),
    .sig    (norm_sig),
    .exp_out(norm_exp)
  );

  always_comb begin
    state_nx = state;
    if (start) begin
      state_nx = UNPACK;
    end else begin
      case (state)
        UNPACK: begin
          case (op)
            FP_MUL:  state_nx = MUL;
            FP_CMP:  state_nx = PACK;
            default: state_nx = ALIGN;
          endcase
        end
        ALIGN:   state_nx = ADD;
        ADD:     state_nx = NORM;
        MUL:     state_nx = (cnt == 4'd10) ? NORM : MUL;
        NORM:    state_nx = PACK;
        PACK:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      done       <= 1'b0;
      result     <= 16'd0;
      OFUF       <= OFUF_OK;
      compResult <= 3'b000;
    end else begin
      state <= state_nx;
      if (state == UNPACK) cnt <= 4'd0;
      else if (state == MUL) cnt <= cnt + 4'd1;
      if (start) begin
        done <= 1'b0;
      end else if (state == PACK) begin
        done <= 1'b1;
        if (op == FP_CMP) begin
          result     <= xl;
          OFUF       <= OFUF_OK;
          compResult <= cmp_fp(xl, yl);
        end else begin
          {OFUF, result} <= pk;
          compResult     <= 3'b000;
        end
      end
    end
  end

  // Datapath registers carry no reset; the FSM decides when they are meaningful.
  always_ff @(posedge clk) begin
    if (start) begin
      xl <= x;
      yl <= y;
      op <= fp_op_e'(opcode);
    end
    case (state)
      UNPACK: begin
        ea     <= ux_e;
        eb     <= uy_e;
        ma     <= ux_sig;
        mb     <= uy_sig;
        sa     <= xl[15];
        sb     <= yl[15] ^ (op == FP_SUB);
        sgn    <= xl[15] ^ yl[15];
        exp_w  <= ux_e + uy_e - 7'(BIAS);
        acc    <= 22'd0;
        mcand  <= {11'd0, ux_sig[13:3]};
        mplier <= uy_sig[13:3];
      end
      ALIGN: begin
        ma    <= x_big ? ma : mb;
        mb    <= (x_big ? mb : ma) >> sh;
        sa    <= x_big ? sa : sb;
        sb    <= x_big ? sb : sa;
        exp_w <= big_e;
      end
      ADD: begin
        mag_w <= addsum;
        sgn   <= (addsum == 15'd0) ? 1'b0 : sa;
      end
      MUL: begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end
      NORM: begin
        n_sig <= norm_sig;
        n_exp <= norm_exp;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_fp16_seq_alu.sv
// Directed self-checking bench for fp16_seq_alu.
module tb_fp16_seq_alu;
  logic        clk = 1'b0;
  logic        reset, start;
  logic [15:0] x, y;
  logic [1:0]  opcode;
  logic [15:0] result;
  logic        done;
  logic [1:0]  OFUF;
  logic [2:0]  compResult;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fp16_seq_alu dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .x         (x),
    .y         (y),
    .opcode    (opcode),
    .result    (result),
    .done      (done),
    .OFUF      (OFUF),
    .compResult(compResult)
  );

  // Drives one request and reports the edge count at which done rose (-1 on timeout).
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                        output int lat, output logic early);
    @(negedge clk);
    x = a; y = b; opcode = op; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    early = done;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; x = 16'h0; y = 16'h0; opcode = 2'd0;
    repeat (2) @(negedge clk);
    n_checks++; if (result !== 16'h0) begin n_fail++; $display("FAIL rst_result: got %h want 0000", result); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
    n_checks++; if (OFUF !== 2'b00) begin n_fail++; $display("FAIL rst_ofuf: got %b want 00", OFUF); end
    n_checks++; if (compResult !== 3'b000) begin n_fail++; $display("FAIL rst_cmp: got %b want 000", compResult); end
    reset = 1'b0;
  endtask

  task automatic test_mul;
    int lat; logic early;
    run_op(16'h3E00, 16'h3E00, 2'd2, lat, early);
    n_checks++; if (early !== 1'b0) begin n_fail++; $display("FAIL mul_done_c1: got %b want 0", early); end
    n_checks++; if (lat !== 14) begin n_fail++; $display("FAIL mul_lat: got %0d want 14", lat); end
    n_checks++; if (result !== 16'h4080) begin n_fail++; $display("FAIL mul_result: got %h want 4080", result); end
    n_checks++; if (OFUF !== 2'b00) begin n_fail++; $display("FAIL mul_ofuf: got %b want 00", OFUF); end
    n_checks++; if (compResult !== 3'b000) begin n_fail++; $display("FAIL mul_cmp: got %b want 000", compResult); end
    run_op(16'hC000, 16'h0000, 2'd2, lat, early);
    n_checks++; if (lat !== 14) begin n_fail++; $display("FAIL mulz_lat: got %0d want 14", lat); end
    n_checks++; if (result !== 16'h8000) begin n_fail++; $display("FAIL mulz_result: got %h want 8000", result); end
  endtask

  task automatic test_sub;
    int lat; logic early;
    run_op(16'h3E00, 16'h3C00, 2'd1, lat, early);
    n_checks++; if (early !== 1'b0) begin n_fail++; $display("FAIL sub_done_c1: got %b want 0", early); end
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL sub_lat: got %0d want 5", lat); end
    n_checks++; if (result !== 16'h3800) begin n_fail++; $display("FAIL sub_result: got %h want 3800", result); end
    run_op(16'h4500, 16'h4500, 2'd1, lat, early);
    n_checks++; if (result !== 16'h0000) begin n_fail++; $display("FAIL sub_zero: got %h want 0000", result); end
    n_checks++; if (OFUF !== 2'b00) begin n_fail++; $display("FAIL sub_zero_ofuf: got %b want 00", OFUF); end
  endtask

  task automatic test_add;
    int lat; logic early;
    run_op(16'h3C00, 16'h3C00, 2'd0, lat, early);
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL add_lat: got %0d want 5", lat); end
    n_checks++; if (result !== 16'h4000) begin n_fail++; $display("FAIL add_result: got %h want 4000", result); end
    run_op(16'h4000, 16'hBC00, 2'd0, lat, early);
    n_checks++; if (result !== 16'h3C00) begin n_fail++; $display("FAIL add_mixed: got %h want 3C00", result); end
  endtask

  task automatic test_ofuf;
    int lat; logic early;
    run_op(16'h7800, 16'h7800, 2'd2, lat, early);
    n_checks++; if (OFUF !== 2'b10) begin n_fail++; $display("FAIL of_flag: got %b want 10", OFUF); end
    n_checks++; if (result !== 16'h7BFF) begin n_fail++; $display("FAIL of_result: got %h want 7BFF", result); end
    run_op(16'h0400, 16'h0400, 2'd2, lat, early);
    n_checks++; if (OFUF !== 2'b01) begin n_fail++; $display("FAIL uf_flag: got %b want 01", OFUF); end
    n_checks++; if (result !== 16'h0000) begin n_fail++; $display("FAIL uf_result: got %h want 0000", result); end
  endtask

  task automatic test_compare;
    int lat; logic early;
    run_op(16'h3C00, 16'hBC00, 2'd3, lat, early);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL cmp_lat: got %0d want 2", lat); end
    n_checks++; if (compResult !== 3'b100) begin n_fail++; $display("FAIL cmp_gt: got %b want 100", compResult); end
    n_checks++; if (result !== 16'h3C00) begin n_fail++; $display("FAIL cmp_pass: got %h want 3C00", result); end
    n_checks++; if (OFUF !== 2'b00) begin n_fail++; $display("FAIL cmp_ofuf: got %b want 00", OFUF); end
    run_op(16'h8000, 16'h0000, 2'd3, lat, early);
    n_checks++; if (compResult !== 3'b010) begin n_fail++; $display("FAIL cmp_zero_eq: got %b want 010", compResult); end
  endtask

  task automatic test_restart;
    int lat; logic seen;
    seen = 1'b0;
    @(negedge clk);
    x = 16'h3E00; y = 16'h3E00; opcode = 2'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    x = 16'h3C00; y = 16'h4000; opcode = 2'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL restart_early_done: got %b want 0", seen); end
    n_checks++; if (lat !== 14) begin n_fail++; $display("FAIL restart_lat: got %0d want 14", lat); end
    n_checks++; if (result !== 16'h4000) begin n_fail++; $display("FAIL restart_result: got %h want 4000", result); end
  endtask

  task automatic test_reset_mid;
    int lat; logic early, seen;
    run_op(16'h3C00, 16'hBC00, 2'd3, lat, early);
    @(negedge clk);
    x = 16'h3E00; y = 16'h3E00; opcode = 2'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    n_checks++; if (result !== 16'h0) begin n_fail++; $display("FAIL midrst_result: got %h want 0000", result); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b want 0", done); end
    n_checks++; if (OFUF !== 2'b00) begin n_fail++; $display("FAIL midrst_ofuf: got %b want 00", OFUF); end
    n_checks++; if (compResult !== 3'b000) begin n_fail++; $display("FAIL midrst_cmp: got %b want 000", compResult); end
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midrst_aborted: got done %b want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_sub();
    test_add();
    test_ofuf();
    test_compare();
    test_restart();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
